// File: rtl/reaction_pkg.sv
// rtl/reaction_pkg.sv - shared round-controller states and default sizing
package reaction_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT_CD,
    MEASURE,
    REPORT
  } state_e;

  localparam int RT_W_DEF    = 16;
  localparam int TIMEOUT_DEF = 1000;

endpackage

// File: rtl/reaction_round_ctrl_rise_detect.sv
// rtl/reaction_round_ctrl_rise_detect.sv - rising-edge detector; resets high so a level held through reset is not an edge
module rise_detect (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic rise_o
);

  logic d_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      d_q <= 1'b1;
    end else begin
      d_q <= d_i;
    end
  end

  assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/reaction_round_ctrl.sv
// rtl/reaction_round_ctrl.sv - starts the countdown, then times the player's press; REACTION_FALSE_START_EN adds false-start detection
module reaction_round_ctrl
  import reaction_pkg::*;
#(
  parameter int RT_W    = RT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic            clk_countdown,
  input  logic            rst,
  input  logic            go,
  input  logic            btn,
  input  logic            cd_in_action,
  input  logic            cd_done,
  output logic            cd_start,
  output logic            busy,
  output logic            result_valid,
  output logic [RT_W-1:0] reaction_time,
  output logic            false_start,
  output logic            timeout
);

  logic            go_rise;
  logic            btn_rise;
  state_e          state_q;
  logic [RT_W-1:0] cnt_q;
  logic            seen_active_q;
  logic            cd_start_q;
  logic            busy_q;
  logic            result_valid_q;
  logic [RT_W-1:0] reaction_time_q;
  logic            false_start_q;
  logic            timeout_q;

  rise_detect u_go_rise (
    .clk_i  (clk_countdown),
    .rst_i  (rst),
    .d_i    (go),
    .rise_o (go_rise)
  );

  rise_detect u_btn_rise (
    .clk_i  (clk_countdown),
    .rst_i  (rst),
    .d_i    (btn),
    .rise_o (btn_rise)
  );

  always_ff @(posedge clk_countdown or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      seen_active_q   <= 1'b0;
      cd_start_q      <= 1'b0;
      busy_q          <= 1'b0;
      result_valid_q  <= 1'b0;
      reaction_time_q <= '0;
      false_start_q   <= 1'b0;
      timeout_q       <= 1'b0;
    end else begin
      cd_start_q <= 1'b0;
      case (state_q)
        IDLE, REPORT: begin
          // Entering ARM: outputs are registered, so the start pulse and cleared result are set here.
          if (go_rise) begin
            state_q         <= ARM;
            cd_start_q      <= 1'b1;
            busy_q          <= 1'b1;
            result_valid_q  <= 1'b0;
            reaction_time_q <= '0;
            false_start_q   <= 1'b0;
            timeout_q       <= 1'b0;
          end
        end
        ARM: begin
          seen_active_q <= 1'b0;
          state_q       <= WAIT_CD;
        end
        WAIT_CD: begin
`ifdef REACTION_FALSE_START_EN
          if (btn_rise) begin
            state_q         <= REPORT;
            busy_q          <= 1'b0;
            result_valid_q  <= 1'b1;
            false_start_q   <= 1'b1;
            reaction_time_q <= '0;
          end else
`endif
          begin
            if (cd_in_action) begin
              seen_active_q <= 1'b1;
            end
            // A done still high from the previous round is ignored until this countdown has run.
            if (cd_done && seen_active_q) begin
              state_q <= MEASURE;
              cnt_q   <= '0;
            end
          end
        end
        MEASURE: begin
          if (btn_rise) begin
            state_q         <= REPORT;
            busy_q          <= 1'b0;
            result_valid_q  <= 1'b1;
            reaction_time_q <= cnt_q;
          end else if (cnt_q == RT_W'(TIMEOUT - 1)) begin
            state_q         <= REPORT;
            busy_q          <= 1'b0;
            result_valid_q  <= 1'b1;
            timeout_q       <= 1'b1;
            reaction_time_q <= RT_W'(TIMEOUT);
          end else begin
            cnt_q <= cnt_q + RT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign cd_start      = cd_start_q;
  assign busy          = busy_q;
  assign result_valid  = result_valid_q;
  assign reaction_time = reaction_time_q;
  assign false_start   = false_start_q;
  assign timeout       = timeout_q;

endmodule

// File: tb/tb_reaction_round_ctrl.sv
// tb/tb_reaction_round_ctrl.sv - directed bench; dut_a uses default TIMEOUT, dut_t uses TIMEOUT=20, both on shared stimulus
module tb_reaction_round_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        go = 1'b0;
  logic        btn = 1'b0;
  logic        cd_in_action = 1'b0;
  logic        cd_done = 1'b0;

  logic        a_start, a_busy, a_rv, a_fs, a_to;
  logic [15:0] a_rt;
  logic        t_start, t_busy, t_rv, t_fs, t_to;
  logic [15:0] t_rt;

  int total = 0;
  int bad = 0;
  int starts_a = 0;

  always #5 clk = ~clk;

  reaction_round_ctrl #(.RT_W(16), .TIMEOUT(1000)) dut_a (
    .clk_countdown (clk),
    .rst           (rst),
    .go            (go),
    .btn           (btn),
    .cd_in_action  (cd_in_action),
    .cd_done       (cd_done),
    .cd_start      (a_start),
    .busy          (a_busy),
    .result_valid  (a_rv),
    .reaction_time (a_rt),
    .false_start   (a_fs),
    .timeout       (a_to)
  );

  reaction_round_ctrl #(.RT_W(16), .TIMEOUT(20)) dut_t (
    .clk_countdown (clk),
    .rst           (rst),
    .go            (go),
    .btn           (btn),
    .cd_in_action  (cd_in_action),
    .cd_done       (cd_done),
    .cd_start      (t_start),
    .busy          (t_busy),
    .result_valid  (t_rv),
    .reaction_time (t_rt),
    .false_start   (t_fs),
    .timeout       (t_to)
  );

  always @(negedge clk) begin
    if (a_start === 1'b1) starts_a++;
  end

  typedef struct {
    int k;
    int rt_a;
    int rt_t;
    int to_t;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    go = 1'b0;
    btn = 1'b0;
    cd_in_action = 1'b0;
    cd_done = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Leaves the bench at the first negedge inside WAIT_CD.
  task automatic start_round(input string tag);
    go = 1'b1;
    @(negedge clk);
    chk({tag, " arm cd_start"}, a_start, 1);
    chk({tag, " arm busy"}, a_busy, 1);
    chk({tag, " arm result_valid"}, a_rv, 0);
    go = 1'b0;
    @(negedge clk);
    chk({tag, " wait cd_start"}, a_start, 0);
  endtask

  // Returns at the negedge where cd_done is raised; the next edge accepts it.
  task automatic countdown(input int pre, input int n_active);
    repeat (pre) @(negedge clk);
    cd_in_action = 1'b1;
    repeat (n_active) @(negedge clk);
    cd_in_action = 1'b0;
    cd_done = 1'b1;
  endtask

  task automatic press(input int k);
    repeat (k + 1) @(negedge clk);
    btn = 1'b1;
    @(negedge clk);
  endtask

  int n_meas;
  int s0;

  initial begin
    vecs[0] = '{k: 37, rt_a: 37, rt_t: 20, to_t: 1};
    vecs[1] = '{k: 0,  rt_a: 0,  rt_t: 0,  to_t: 0};
    vecs[2] = '{k: 5,  rt_a: 5,  rt_t: 5,  to_t: 0};
    vecs[3] = '{k: 19, rt_a: 19, rt_t: 19, to_t: 0};
    vecs[4] = '{k: 20, rt_a: 20, rt_t: 20, to_t: 1};

    @(negedge clk);
    chk("reset cd_start", a_start, 0);
    chk("reset busy", a_busy, 0);
    chk("reset result_valid", a_rv, 0);
    chk("reset reaction_time", a_rt, 0);
    chk("reset false_start", a_fs, 0);
    chk("reset timeout", a_to, 0);

    for (int i = 0; i < 5; i++) begin
      do_reset();
      s0 = starts_a;
      start_round("vec");
      countdown(0, 4);
      press(vecs[i].k);
      chk("vec a result_valid", a_rv, 1);
      chk("vec a busy", a_busy, 0);
      chk("vec a reaction_time", a_rt, vecs[i].rt_a);
      chk("vec a timeout", a_to, 0);
      chk("vec a false_start", a_fs, 0);
      chk("vec t result_valid", t_rv, 1);
      chk("vec t reaction_time", t_rt, vecs[i].rt_t);
      chk("vec t timeout", t_to, vecs[i].to_t);
      chk("vec single cd_start", starts_a - s0, 1);
    end

    // REPORT: btn ignored, go starts a new round directly.
    btn = 1'b0;
    @(negedge clk);
    btn = 1'b1;
    @(negedge clk);
    chk("report btn ignored rt", a_rt, 20);
    chk("report btn ignored rv", a_rv, 1);
    start_round("rearm");
    chk("rearm rt cleared", a_rt, 0);
    btn = 1'b0;

    // Timeout with no press on dut_t: exactly 20 MEASURE cycles.
    do_reset();
    start_round("tmo");
    countdown(0, 4);
    n_meas = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (t_rv === 1'b1) break;
      if (t_busy === 1'b1) n_meas++;
    end
    chk("tmo result_valid", t_rv, 1);
    chk("tmo measure cycles", n_meas, 20);
    chk("tmo reaction_time", t_rt, 20);
    chk("tmo timeout", t_to, 1);
    chk("tmo a still busy", a_busy, 1);

    // Stale done held across ARM, in_action delayed 3 cycles.
    do_reset();
    cd_done = 1'b1;
    start_round("stale");
    repeat (3) @(negedge clk);
    cd_in_action = 1'b1;
    repeat (2) @(negedge clk);
    cd_in_action = 1'b0;
    repeat (3) @(negedge clk);
    btn = 1'b1;
    @(negedge clk);
    chk("stale rv", a_rv, 1);
    chk("stale reaction_time", a_rt, 3);

    // Press while the countdown runs.
    do_reset();
    start_round("fs");
    cd_in_action = 1'b1;
    @(negedge clk);
    btn = 1'b1;
    @(negedge clk);
`ifdef REACTION_FALSE_START_EN
    chk("fs result_valid", a_rv, 1);
    chk("fs false_start", a_fs, 1);
    chk("fs reaction_time", a_rt, 0);
    chk("fs busy", a_busy, 0);
`else
    chk("fs ignored rv", a_rv, 0);
    chk("fs ignored busy", a_busy, 1);
    chk("fs ignored false_start", a_fs, 0);
    btn = 1'b0;
    repeat (2) @(negedge clk);
    cd_in_action = 1'b0;
    cd_done = 1'b1;
    press(6);
    chk("fs measured rv", a_rv, 1);
    chk("fs measured rt", a_rt, 6);
    chk("fs measured false_start", a_fs, 0);
`endif

    // go rise during MEASURE is ignored.
    do_reset();
    start_round("goign");
    s0 = starts_a;
    countdown(0, 4);
    repeat (2) @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    repeat (8) @(negedge clk);
    btn = 1'b1;
    @(negedge clk);
    chk("goign rt", a_rt, 10);
    chk("goign no restart", starts_a - s0, 0);

    // Asynchronous reset mid-MEASURE, go held through release.
    do_reset();
    start_round("rst");
    countdown(0, 4);
    repeat (5) @(negedge clk);
    go = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("rst async busy", a_busy, 0);
    chk("rst async rv", a_rv, 0);
    chk("rst async rt", a_rt, 0);
    cd_in_action = 1'b0;
    cd_done = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    s0 = starts_a;
    repeat (5) @(negedge clk);
    chk("rst go held no start", starts_a - s0, 0);
    chk("rst go held busy", a_busy, 0);
    go = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reaction_round_ctrl.md
# reaction_round_ctrl

Round controller that drives the countdown block from the initiator side: it issues the countdown start pulse, tracks the countdown's in-action/done handshake, then measures player reaction time in clk_countdown cycles. It sits between the game-level inputs (go request, debounced player button) and the countdown/display path, and presents one result per round to the score/display logic.

## Interface
- RT_W, 16, width of reaction_time counter
- TIMEOUT, 1000, MEASURE-state cycle limit; must be > 0 and < 2^RT_W
- clk_countdown  in  1  round clock, shared with countdown block
- rst  in  1  reset, asynchronous, active-high
- go  in  1  round request level; rising edge acts
- btn  in  1  player button, debounced, synchronous to clk_countdown; rising edge acts
- cd_in_action  in  1  countdown running (from countdown block)
- cd_done  in  1  countdown finished, held until next start (from countdown block)
- cd_start  out  1  one-cycle start pulse to countdown block
- busy  out  1  high in ARM, WAIT_CD, MEASURE
- result_valid  out  1  high in REPORT
- reaction_time  out  RT_W  measured cycles; valid while result_valid
- false_start  out  1  round ended by press during countdown
- timeout  out  1  round ended with no press within TIMEOUT

## Operation
- Edge detect: go_q, btn_q registers; go_rise = go & ~go_q, btn_rise = btn & ~btn_q. go_q/btn_q reset to 1 (input held through reset gives no edge).
- States: IDLE, ARM, WAIT_CD, MEASURE, REPORT.
- IDLE: go_rise -> ARM. Result outputs 0.
- ARM: cd_start = 1 for exactly this cycle; clear reaction_time, false_start, timeout, seen_active; -> WAIT_CD.
- WAIT_CD: set seen_active when cd_in_action = 1. cd_done accepted only when seen_active = 1 (stale done from previous round ignored). Accepted done -> MEASURE, cnt <= 0.
- WAIT_CD false start (macro enabled): btn_rise -> REPORT, false_start = 1, reaction_time = 0. Takes priority over same-cycle cd_done.
- MEASURE: cnt increments by 1 each cycle. btn_rise in cycle where cnt = k -> REPORT, reaction_time = k. Else if cnt = TIMEOUT-1 -> REPORT, timeout = 1, reaction_time = TIMEOUT. btn_rise wins over same-cycle timeout.
- REPORT: outputs held; go_rise -> ARM (new round directly). btn ignored.
- go_rise ignored in ARM, WAIT_CD, MEASURE.
- cnt never exceeds TIMEOUT; no wrap.

## Timing
- Reset values: cd_start 0, busy 0, result_valid 0, reaction_time 0, false_start 0, timeout 0; state IDLE.
- go rising sampled at edge N -> cd_start high during cycle N+1 -> WAIT_CD at N+2.
- cd_done accepted at edge M -> first MEASURE cycle (cnt = 0) after M.
- btn_rise sampled at edge P -> result_valid and reaction_time valid after P (1-cycle latency).
- rst mid-round: immediate return to IDLE, all outputs to reset values; countdown shares rst.
- All outputs registered; no combinational input-to-output paths.

## Configuration
- REACTION_FALSE_START_EN defined: btn_rise in WAIT_CD ends round as false start (above).
- Undefined: btn ignored in WAIT_CD; false_start tied 0; round always reaches MEASURE.

## Structure
- Shared package reaction_pkg: state enum (IDLE, ARM, WAIT_CD, MEASURE, REPORT), RT_W default, TIMEOUT default.
- Sub-module rise_detect (register + rising-edge output, reset value 1), instantiated for go and btn.

## Test plan
- Reset, go pulse, countdown model asserts in_action 4 cycles then done, btn rise 37 cycles into MEASURE -> cd_start single pulse, result_valid, reaction_time = 37, false_start 0, timeout 0.
- Macro on, btn rise while cd_in_action = 1 -> REPORT next cycle, false_start 1, reaction_time 0; macro off, same stimulus -> ignored, round reaches MEASURE.
- No btn, TIMEOUT = 20 -> timeout 1, reaction_time 20, exactly 20 MEASURE cycles.
- cd_done held high from prior round at ARM, in_action delayed 3 cycles -> no MEASURE entry before in_action seen.
- btn_rise and cnt = TIMEOUT-1 same cycle -> reaction_time = TIMEOUT-1, timeout 0; go_rise in MEASURE ignored.
- rst asserted mid-MEASURE -> all outputs 0 asynchronously, IDLE; go held through rst release -> no round starts.
